vga_text_ctrl: RTL and testbench

//  Upstream stage of the per-pixel glyph renderer. Generates 640x480@60 VGA timing on pclk and

---
 rtl/vga_text_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_vga_text_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_ctrl.sv
// vga_text_ctrl: VGA timing generator and text-buffer walker feeding the glyph renderer.
// Optional cursor blink is built in when CURSOR_BLINK_EN is defined.
module vga_text_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CHAR_W   = 9,
    parameter int CHAR_H   = 16,
    parameter int COLS     = 70,
`ifdef CURSOR_BLINK_EN
    parameter int BLINK_FRAMES = 30,
`endif
    parameter int ROWS     = 30
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [4:0]  scroll_row,
    input  logic [6:0]  cur_col,
    input  logic [4:0]  cur_row,
    output logic [11:0] ram_addr,
    input  logic [7:0]  ram_data,
    output logic [7:0]  char,
    output logic [3:0]  h_font,
    output logic [3:0]  v_font,
    output logic        c_valid,
    output logic        cursor,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic        frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [3:0] CW     = 4'(CHAR_W);
    localparam logic [3:0] CH_LST = 4'(CHAR_H - 1);
    localparam logic [6:0] NCOL   = 7'(COLS);
    localparam logic [4:0] NROW   = 5'(ROWS);
    localparam logic [5:0] NROW6  = 6'(ROWS);

    logic        run_q;
    logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [3:0]  hf_q, hf_d, vf_q, vf_d;
    logic [6:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic [4:0]  scr_q, scr_d, cr_q, cr_d;
    logic [6:0]  cc_q, cc_d;
    logic        h_end, v_end, act0, blink;
    logic [5:0]  sum;
    logic [4:0]  brow;
    logic [11:0] addr_d, addr_q;
    logic        cv0, cur0, hs0, vs0;
    logic [3:0]  hf1_q, vf1_q, hf2_q, vf2_q;
    logic        cv1_q, cur1_q, vld1_q, cv2_q, cur2_q, vld2_q;
    logic [2:0]  hs_q, vs_q, bl_q;

    // run_q holds the counters for the reset-exit cycle so the
    // first live cycle lands on pixel (0,0)
    assign h_end = hcnt_q == H_LAST;
    assign v_end = vcnt_q == V_LAST;
    assign act0  = run_q && (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    assign frame_start = run_q && (hcnt_q == '0) && (vcnt_q == '0);

    // stage-0 pixel counters and incremental cell counters
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        hf_d   = hf_q;
        col_d  = col_q;
        vf_d   = vf_q;
        row_d  = row_q;
        if (run_q) begin
            hcnt_d = h_end ? '0 : hcnt_q + 10'd1;
            if (h_end) begin
                hf_d   = 4'd1;
                col_d  = '0;
                vcnt_d = v_end ? '0 : vcnt_q + 10'd1;
                if (v_end) begin
                    vf_d  = '0;
                    row_d = '0;
                end else if (vcnt_q < V_ACT) begin
                    if (vf_q == CH_LST) begin
                        vf_d  = '0;
                        row_d = row_q + 5'd1;
                    end else begin
                        vf_d = vf_q + 4'd1;
                    end
                end
            end else if (act0) begin
                if (hf_q == CW) begin
                    hf_d  = 4'd1;
                    col_d = col_q + 7'd1;
                end else begin
                    hf_d = hf_q + 4'd1;
                end
            end
        end
    end

    // counter state registers
    always_ff @(posedge pclk) begin
        if (!rst) begin
            run_q  <= 1'b0;
            hcnt_q <= '0;
            vcnt_q <= '0;
            hf_q   <= 4'd1;
            col_q  <= '0;
            vf_q   <= '0;
            row_q  <= '0;
        end else begin
            run_q  <= 1'b1;
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            hf_q   <= hf_d;
            col_q  <= col_d;
            vf_q   <= vf_d;
            row_q  <= row_d;
        end
    end

    // frame-start values apply to pixel (0,0) too, then hold all frame
    assign scr_d = frame_start ? ((scroll_row >= NROW) ? '0 : scroll_row)
                               : scr_q;
    assign cc_d  = frame_start ? cur_col : cc_q;
    assign cr_d  = frame_start ? cur_row : cr_q;

    // per-frame sampled scroll and cursor position
    always_ff @(posedge pclk) begin
        if (!rst) begin
            scr_q <= '0;
            cc_q  <= '0;
            cr_q  <= '0;
        end else begin
            scr_q <= scr_d;
            cc_q  <= cc_d;
            cr_q  <= cr_d;
        end
    end

`ifdef CURSOR_BLINK_EN
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          blink_q, blink_d;

    // frame counter toggles the blink phase every BLINK_FRAMES frames
    always_comb begin
        fcnt_d  = fcnt_q;
        blink_d = blink_q;
        if (run_q && h_end && v_end) begin
            if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
                fcnt_d  = '0;
                blink_d = !blink_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
    end

    // blink state registers
    always_ff @(posedge pclk) begin
        if (!rst) begin
            fcnt_q  <= '0;
            blink_q <= 1'b1;
        end else begin
            fcnt_q  <= fcnt_d;
            blink_q <= blink_d;
        end
    end

    assign blink = blink_q;
`else
    assign blink = 1'b1;
`endif

    // ring-buffer row: one conditional subtract replaces the modulo
    assign sum    = {1'b0, row_q} + {1'b0, scr_d};
    assign brow   = (sum >= NROW6) ? 5'(sum - NROW6) : sum[4:0];
    assign addr_d = (run_q && col_q < NCOL)
                  ? 12'(brow) * 12'(COLS) + 12'(col_q) : '0;
    assign cv0    = act0 && (col_q < NCOL) && (row_q < NROW);
    assign cur0   = cv0 && (col_q == cc_d) && (row_q == cr_d) && blink;
    assign hs0    = !(hcnt_q >= HS_BEG && hcnt_q <= HS_END);
    assign vs0    = !(vcnt_q >= VS_BEG && vcnt_q <= VS_END);

    // two-stage cell pipeline aligned with the RAM read latency
    always_ff @(posedge pclk) begin
        if (!rst) begin
            addr_q <= '0;
            hf1_q  <= 4'd1;
            vf1_q  <= '0;
            cv1_q  <= 1'b0;
            cur1_q <= 1'b0;
            vld1_q <= 1'b0;
            hf2_q  <= 4'd1;
            vf2_q  <= '0;
            cv2_q  <= 1'b0;
            cur2_q <= 1'b0;
            vld2_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            hf1_q  <= hf_q;
            vf1_q  <= vf_q;
            cv1_q  <= cv0;
            cur1_q <= cur0;
            vld1_q <= run_q;
            hf2_q  <= hf1_q;
            vf2_q  <= vf1_q;
            cv2_q  <= cv1_q;
            cur2_q <= cur1_q;
            vld2_q <= vld1_q;
        end
    end

    // three-deep sync/blank delay matching the renderer output register
    always_ff @(posedge pclk) begin
        if (!rst) begin
            hs_q <= '1;
            vs_q <= '1;
            bl_q <= '0;
        end else begin
            hs_q <= {hs_q[1:0], hs0};
            vs_q <= {vs_q[1:0], vs0};
            bl_q <= {bl_q[1:0], act0};
        end
    end

    assign ram_addr = addr_q;
    assign char     = vld2_q ? ram_data : '0;
    assign h_font   = hf2_q;
    assign v_font   = vf2_q;
    assign c_valid  = cv2_q;
    assign cursor   = cur2_q;
    assign hsync    = hs_q[2];
    assign vsync    = vs_q[2];
    assign blank_n  = bl_q[2];

endmodule

// File: tb/tb_vga_text_ctrl.sv
// tb_vga_text_ctrl: bench for vga_text_ctrl on a reduced screen geometry.
// Pixel-level reference model plus directed table and corner sequences.
module tb_vga_text_ctrl;

    localparam int HA = 40, HF = 4, HS = 6, HB = 6;
    localparam int VA = 52, VF = 3, VS = 2, VB = 4;
    localparam int CW = 9, CH = 16, NC = 4, NR = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic        pclk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  scroll_row = '0;
    logic [6:0]  cur_col = '0;
    logic [4:0]  cur_row = '0;
    logic [11:0] ram_addr;
    logic [7:0]  ram_data;
    logic [7:0]  char;
    logic [3:0]  h_font, v_font;
    logic        c_valid, cursor, hsync, vsync, blank_n, frame_start;

    always #5 pclk = ~pclk;

    // text RAM returns the low address byte one clock later
    always @(posedge pclk) ram_data <= ram_addr[7:0];

    vga_text_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CHAR_W(CW), .CHAR_H(CH), .COLS(NC), .ROWS(NR)
    ) dut (
        .pclk(pclk), .rst(rst),
        .scroll_row(scroll_row), .cur_col(cur_col), .cur_row(cur_row),
        .ram_addr(ram_addr), .ram_data(ram_data), .char(char),
        .h_font(h_font), .v_font(v_font), .c_valid(c_valid),
        .cursor(cursor), .hsync(hsync), .vsync(vsync),
        .blank_n(blank_n), .frame_start(frame_start)
    );

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  ch;
        logic [3:0]  hf;
        logic [3:0]  vf;
        logic        cv;
        logic        cur;
        logic        hs;
        logic        vs;
        logic        bl;
    } rec_t;

    localparam rec_t IDLE = '{12'd0, 8'd0, 4'd1, 4'd0,
                              1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    typedef struct {
        int          hc;
        int          vc;
        logic [11:0] addr;
        logic [3:0]  hf;
        logic [3:0]  vf;
        logic        cv;
        logic        cur;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    int   m_hc = 0, m_vc = 0, m_s = 0, m_cc = 0, m_cr = 0;
    bit   m_run = 0;
    bit   m_fs = 0;
    rec_t h[4];

    task automatic chk(input string nm, input logic [33:0] a,
                       input logic [33:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s at h=%0d v=%0d: got %h want %h",
                     nm, m_hc, m_vc, a, e);
        end
    endtask

    // expected stage-0 bundle of one pixel, straight from the screen geometry
    function automatic rec_t pix(int hc, int vc, int s, int cc, int cr);
        rec_t p;
        int   hp, vp, col, row;
        bit   act;
        act = (hc < HA) && (vc < VA);
        vp  = (vc < VA) ? vc : VA;
        hp  = (vc < VA) ? ((hc < HA) ? hc : HA) : 0;
        col = hp / CW;
        row = vp / CH;
        p.hf   = 4'(hp % CW + 1);
        p.vf   = 4'(vp % CH);
        p.addr = (col >= NC) ? 12'd0 : 12'(((row + s) % NR) * NC + col);
        p.ch   = p.addr[7:0];
        p.cv   = act && col < NC && row < NR;
        p.cur  = p.cv && col == cc && row == cr;
        p.hs   = !(hc >= HA + HF && hc < HA + HF + HS);
        p.vs   = !(vc >= VA + VF && vc < VA + VF + VS);
        p.bl   = act;
        return p;
    endfunction

    // one clock: advance the model, drive inputs, compare every output
    task automatic step(input bit r, input int s, input int cc, input int cr);
        bit rs;
        @(posedge pclk);
        rs = rst;
        #1;
        if (!rs) begin
            m_run = 0; m_hc = 0; m_vc = 0;
            m_s = 0; m_cc = 0; m_cr = 0;
            h[1] = IDLE; h[2] = IDLE; h[3] = IDLE;
        end else begin
            if (m_run) begin
                m_hc++;
                if (m_hc == HT) begin
                    m_hc = 0;
                    m_vc = (m_vc == VT - 1) ? 0 : m_vc + 1;
                end
            end else begin
                m_run = 1;
            end
            h[3] = h[2]; h[2] = h[1]; h[1] = h[0];
        end
        rst = r;
        scroll_row = 5'(s);
        cur_col = 7'(cc);
        cur_row = 5'(cr);
        m_fs = m_run && m_hc == 0 && m_vc == 0;
        if (m_fs) begin
            m_s = (s >= NR) ? 0 : s;
            m_cc = cc;
            m_cr = cr;
        end
        h[0] = m_run ? pix(m_hc, m_vc, m_s, m_cc, m_cr) : IDLE;
        chk("pixel", {ram_addr, char, h_font, v_font, c_valid, cursor,
                      hsync, vsync, blank_n, frame_start},
            {h[1].addr, h[2].ch, h[2].hf, h[2].vf, h[2].cv, h[2].cur,
             h[3].hs, h[3].vs, h[3].bl, m_fs});
    endtask

    task automatic seek(input int hc, input int vc, input int s,
                        input int cc, input int cr);
        int n = 0;
        while (!(m_run && m_hc == hc && m_vc == vc)) begin
            step(1, s, cc, cr);
            n++;
            if (n > 2 * HT * VT) begin
                checks++;
                failures++;
                $display("FAIL seek timeout target h=%0d v=%0d", hc, vc);
                return;
            end
        end
    endtask

    vec_t tbl[11];

    initial begin
        int          nh, nv, nb, nf;
        logic [11:0] a;

        // pixel positions in frame 0 with scroll=2, cursor (1,1) sampled
        tbl[0]  = '{0,  0,  12'd8, 4'd1, 4'd0,  1'b1, 1'b0};
        tbl[1]  = '{8,  0,  12'd8, 4'd9, 4'd0,  1'b1, 1'b0};
        tbl[2]  = '{17, 0,  12'd9, 4'd9, 4'd0,  1'b1, 1'b0};
        tbl[3]  = '{9,  16, 12'd1, 4'd1, 4'd0,  1'b1, 1'b1};
        tbl[4]  = '{35, 20, 12'd3, 4'd9, 4'd4,  1'b1, 1'b0};
        tbl[5]  = '{38, 21, 12'd0, 4'd3, 4'd5,  1'b0, 1'b0};
        tbl[6]  = '{17, 31, 12'd1, 4'd9, 4'd15, 1'b1, 1'b1};
        tbl[7]  = '{20, 31, 12'd2, 4'd3, 4'd15, 1'b1, 1'b0};
        tbl[8]  = '{5,  32, 12'd4, 4'd6, 4'd0,  1'b1, 1'b0};
        tbl[9]  = '{5,  48, 12'd8, 4'd6, 4'd0,  1'b0, 1'b0};
        tbl[10] = '{20, 56, 12'd8, 4'd1, 4'd4,  1'b0, 1'b0};

        h[0] = IDLE; h[1] = IDLE; h[2] = IDLE; h[3] = IDLE;

        step(0, 2, 1, 1);
        step(0, 2, 1, 1);
        step(1, 2, 1, 1);
        step(1, 2, 1, 1);
        chk("first_fs", 34'(frame_start), 34'(1));

        // mid-frame input changes must not affect frame 0
        foreach (tbl[i]) begin
            seek(tbl[i].hc, tbl[i].vc, 0, 3, 2);
            a = tbl[i].addr;
            step(1, 0, 3, 2);
            chk("tbl_addr", 34'(ram_addr), 34'(a));
            step(1, 0, 3, 2);
            chk("tbl_cell", 34'({char, h_font, v_font, c_valid, cursor}),
                34'({a[7:0], tbl[i].hf, tbl[i].vf, tbl[i].cv, tbl[i].cur}));
        end

        // one-cycle reset in the middle of a frame
        seek(30, 20, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("rst_outputs", {ram_addr, char, h_font, v_font, c_valid, cursor,
                            hsync, vsync, blank_n, frame_start},
            {IDLE, 1'b0});
        step(1, 1, 0, 0);
        chk("rst_release_fs", 34'(frame_start), 34'(1));

        // sync and blank duty over exactly one frame
        seek(0, 1, 1, 0, 0);
        nh = 0; nv = 0; nb = 0; nf = 0;
        for (int i = 0; i < HT * VT; i++) begin
            step(1, $urandom_range(0, 3), $urandom_range(0, NC),
                 $urandom_range(0, NR));
            if (hsync == 1'b0) nh++;
            if (vsync == 1'b0) nv++;
            if (blank_n == 1'b1) nb++;
            if (frame_start == 1'b1) nf++;
        end
        chk("hsync_low_cycles", 34'(nh), 34'(VT * HS));
        chk("vsync_low_cycles", 34'(nv), 34'(VS * HT));
        chk("blank_high_cycles", 34'(nb), 34'(HA * VA));
        chk("frame_starts", 34'(nf), 34'(1));

        // random inputs every cycle with rare resets
        for (int i = 0; i < 8 * HT * VT; i++) begin
            step($urandom_range(0, 2999) != 0, $urandom_range(0, 3),
                 $urandom_range(0, NC), $urandom_range(0, NR));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
